// File: rtl/dsp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dsp_pkg : shared width/rounding helpers for the receive DSP chain    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package dsp_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Width needed to sum 2^log2_dec samples of data_width bits without overflow.
  function automatic int acc_width(input int data_width, input int log2_dec);
    return data_width + log2_dec;
  endfunction

  function automatic int round_const(input int shift);
    return (shift == 0) ? 0 : (1 << (shift - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/round_shift_right.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | round_shift_right : round-half-up arithmetic right shift, narrowing  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module round_shift_right
  import dsp_pkg::*;
#(
  parameter int IN_WIDTH  = 19,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 3
) (
  input  logic signed [IN_WIDTH-1:0]  acc,
  output logic signed [OUT_WIDTH-1:0] result
);

  generate
    if (SHIFT == 0) begin : g_pass
      assign result = acc[OUT_WIDTH-1:0];
    end else begin : g_round
      localparam logic signed [IN_WIDTH-1:0] ROUND = IN_WIDTH'(round_const(SHIFT));
      logic signed [IN_WIDTH-1:0] biased;

      // A full-scale block sum plus half an LSB still fits IN_WIDTH, so no guard bit.
      assign biased = acc + ROUND;
      assign result = biased[SHIFT +: OUT_WIDTH];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/boxcar_decimator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | boxcar_decimator : integrate-and-dump by 2^LOG2_DECIMATION, held out |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module boxcar_decimator
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int LOG2_DECIMATION = 3
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  input  logic                         i_data_valid,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_data_valid,
  input  logic                         i_data_ready,
  output logic                         o_overrun,
  input  logic                         i_clear_overrun
);

  localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, LOG2_DECIMATION);
  localparam int DECIMATION = 1 << LOG2_DECIMATION;
  localparam int CNT_WIDTH  = (clog2(DECIMATION) > 0) ? clog2(DECIMATION) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DECIMATION - 1);

  logic [CNT_WIDTH-1:0]         count;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  sample_ext;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic signed [DATA_WIDTH-1:0] result;
  logic                         dump;
  logic                         overwrite;

  assign sample_ext = ACC_WIDTH'(i_data);
  assign sum        = acc + sample_ext;
  assign dump       = i_data_valid && (count == LAST);
  assign overwrite  = dump && o_data_valid && !i_data_ready;

  round_shift_right #(
    .IN_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH (DATA_WIDTH),
    .SHIFT     (LOG2_DECIMATION)
  ) u_round (
    .acc    (sum),
    .result (result)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc   <= '0;
      count <= '0;
    end else if (i_data_valid) begin
      if (dump) begin
        acc   <= '0;
        count <= '0;
      end else begin
        acc   <= sum;
        count <= count + 1'b1;
      end
    end
  end

  // A fresh result always wins the holding register; a consume on the same edge is not an overrun.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data       <= '0;
      o_data_valid <= 1'b0;
    end else if (dump) begin
      o_data       <= result;
      o_data_valid <= 1'b1;
    end else if (o_data_valid && i_data_ready) begin
      o_data_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overrun <= 1'b0;
    end else if (overwrite) begin
      o_overrun <= 1'b1;
    end else if (i_clear_overrun) begin
      o_overrun <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_boxcar_decimator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_boxcar_decimator : table vectors, random stimulus vs. block model |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_boxcar_decimator;

  localparam int DW = 16;
  localparam int L  = 2;
  localparam int D  = 1 << L;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [DW-1:0] data = '0;
  logic                 valid = 1'b0;
  logic                 ready = 1'b0;
  logic                 clr = 1'b0;
  logic signed [DW-1:0] o_data;
  logic                 o_valid;
  logic                 o_ov;

  int errors = 0;
  int checks = 0;

  // Reference: accepted samples of the open block and the expected output register.
  int blk[$];
  int m_d;
  bit m_v;
  bit m_ov;

  typedef struct {
    bit v;
    int d;
    bit rdy;
    bit clr;
    int ed;
    bit ev;
    bit eov;
  } vec_t;
  vec_t vecs[$];

  boxcar_decimator #(
    .DATA_WIDTH      (DW),
    .LOG2_DECIMATION (L)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_data          (data),
    .i_data_valid    (valid),
    .o_data          (o_data),
    .o_data_valid    (o_valid),
    .i_data_ready    (ready),
    .o_overrun       (o_ov),
    .i_clear_overrun (clr)
  );

  always #5 clk = ~clk;

  function automatic void add(bit v, int d, bit rdy, bit c, int ed, bit ev, bit eov);
    vec_t t;
    t.v = v; t.d = d; t.rdy = rdy; t.clr = c; t.ed = ed; t.ev = ev; t.eov = eov;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    blk.delete();
    m_d  = 0;
    m_v  = 0;
    m_ov = 0;
  endfunction

  // Mean of the block rounded half toward +inf, by floor division.
  function automatic int rounded_mean();
    int s;
    s = D / 2;
    foreach (blk[i]) s += blk[i];
    if (s >= 0) return s / D;
    return -((-s + D - 1) / D);
  endfunction

  function automatic void model_step(bit v, int d, bit rdy, bit c);
    bit is_dump;
    bit ovw;
    is_dump = v && (blk.size() == D - 1);
    if (v) blk.push_back(d);
    if (is_dump) begin
      ovw = m_v && !rdy;
      m_d = rounded_mean();
      m_v = 1;
      blk.delete();
      if (ovw) m_ov = 1;
      else if (c) m_ov = 0;
    end else begin
      if (m_v && rdy) m_v = 0;
      if (c) m_ov = 0;
    end
  endfunction

  // Called at a falling edge: drive, let one rising edge pass, compare on the next falling edge.
  task automatic cycle(input bit v, input int d, input bit rdy, input bit c);
    valid = v;
    data  = d[DW-1:0];
    ready = rdy;
    clr   = c;
    @(posedge clk);
    model_step(v, d, rdy, c);
    @(negedge clk);
    if (m_v) check("model_data", int'(o_data), m_d);
    check("model_valid", int'(o_valid), int'(m_v));
    check("model_overrun", int'(o_ov), int'(m_ov));
  endtask

  initial begin
    logic [DW-1:0] r;
    int d;

    // Basic blocks and extremes, ready held high.
    add(1, 1, 1, 0, 0, 0, 0);           add(1, 2, 1, 0, 0, 0, 0);
    add(1, 3, 1, 0, 0, 0, 0);           add(1, 4, 1, 0, 3, 1, 0);
    add(1, -1, 1, 0, 3, 0, 0);          add(1, -1, 1, 0, 3, 0, 0);
    add(1, -1, 1, 0, 3, 0, 0);          add(1, -2, 1, 0, -1, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 32767, 1, 0, (i == 0) ? -1 : -1, 0, 0);
    add(1, 32767, 1, 0, 32767, 1, 0);
    for (int i = 0; i < 3; i++) add(1, -32768, 1, 0, 32767, 0, 0);
    add(1, -32768, 1, 0, -32768, 1, 0);
    // Gapped valid 1,0,0,1,0,1,1; idle-cycle data must be ignored.
    add(1, 8, 1, 0, -32768, 0, 0);      add(0, 99, 1, 0, -32768, 0, 0);
    add(0, 99, 1, 0, -32768, 0, 0);     add(1, 8, 1, 0, -32768, 0, 0);
    add(0, 99, 1, 0, -32768, 0, 0);     add(1, 8, 1, 0, -32768, 0, 0);
    add(1, 8, 1, 0, 8, 1, 0);
    // Backpressure, overrun, clear, then consume.
    add(0, 99, 1, 0, 8, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 5, 0, 0, 8, 0, 0);
    add(1, 5, 0, 0, 5, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 5, 0, 0, 5, 1, 0);
    add(1, 5, 0, 0, 5, 1, 1);
    add(0, 0, 0, 1, 5, 1, 0);           add(0, 0, 1, 0, 5, 0, 0);
    // Consume on the same edge as the next dump.
    for (int i = 0; i < 3; i++) add(1, 10, 0, 0, 0, 0, 0);
    add(1, 10, 0, 0, 10, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 12, 0, 0, 10, 1, 0);
    add(1, 12, 1, 0, 12, 1, 0);
    add(0, 0, 1, 0, 12, 0, 0);

    model_reset();
    @(negedge clk);
    check("reset_data", int'(o_data), 0);
    check("reset_valid", int'(o_valid), 0);
    check("reset_overrun", int'(o_ov), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].rdy, vecs[i].clr);
      if (vecs[i].ev) check($sformatf("vec%0d_data", i), int'(o_data), vecs[i].ed);
      check($sformatf("vec%0d_valid", i), int'(o_valid), int'(vecs[i].ev));
      check($sformatf("vec%0d_overrun", i), int'(o_ov), int'(vecs[i].eov));
    end

    for (int i = 0; i < 600; i++) begin
      r = DW'($urandom);
      case ($urandom_range(0, 7))
        0: d = 32767;
        1: d = -32768;
        default: d = int'($signed(r));
      endcase
      cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0,
            $urandom_range(0, 7) == 0);
    end

    // Asynchronous reset in the middle of a block.
    for (int i = 0; i < 4; i++) cycle(1, 100, 0, 0);
    cycle(1, 100, 0, 0);
    cycle(1, 100, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_data", int'(o_data), 0);
    check("async_rst_valid", int'(o_valid), 0);
    check("async_rst_overrun", int'(o_ov), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1, 8, 1, 0);
    check("post_rst_data", int'(o_data), 8);
    check("post_rst_valid", int'(o_valid), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
